// File: rtl/pcileech_tx_pack4_if.sv
// Bus bundle between the four TX sources, the packer and the 256-bit TX buffer FIFO.
// The master modport is the packer's view; slave is the sources/consumer side.
interface pcileech_tx_pack4_if;
  logic [255:0] dout;
  logic         valid;
  logic         rd_en;

  logic [31:0]  p0_din;
  logic [31:0]  p1_din;
  logic [31:0]  p2_din;
  logic [31:0]  p3_din;
  logic [1:0]   p0_ctx;
  logic [1:0]   p1_ctx;
  logic [1:0]   p2_ctx;
  logic [1:0]   p3_ctx;
  logic         p0_wr_en;
  logic         p1_wr_en;
  logic         p2_wr_en;
  logic         p3_wr_en;
  logic         p0_has_data;
  logic         p1_has_data;
  logic         p2_has_data;
  logic         p3_has_data;
  logic         p0_req_data;
  logic         p1_req_data;
  logic         p2_req_data;
  logic         p3_req_data;

  modport master (
    output dout, valid,
    output p0_req_data, p1_req_data, p2_req_data, p3_req_data,
    input  rd_en,
    input  p0_din, p1_din, p2_din, p3_din,
    input  p0_ctx, p1_ctx, p2_ctx, p3_ctx,
    input  p0_wr_en, p1_wr_en, p2_wr_en, p3_wr_en,
    input  p0_has_data, p1_has_data, p2_has_data, p3_has_data
  );

  modport slave (
    input  dout, valid,
    input  p0_req_data, p1_req_data, p2_req_data, p3_req_data,
    output rd_en,
    output p0_din, p1_din, p2_din, p3_din,
    output p0_ctx, p1_ctx, p2_ctx, p3_ctx,
    output p0_wr_en, p1_wr_en, p2_wr_en, p3_wr_en,
    output p0_has_data, p1_has_data, p2_has_data, p3_has_data
  );
endinterface

// File: rtl/pcileech_tx_pack4.sv
// Strict-priority 4-port packer: tags 32-bit source words with {ctx, port} and packs up to
// seven of them per 256-bit output word, flushing partial packs once the sources go idle.
module pcileech_tx_pack4 (
  input  logic               clk,
  input  logic               rst,
  pcileech_tx_pack4_if.master bus_io
);

  localparam int unsigned NumSlots = 7;

  logic [3:0]  has;
  logic [3:0]  wr;
  logic [31:0] din [4];
  logic [1:0]  ctx [4];

  assign has = {bus_io.p3_has_data, bus_io.p2_has_data, bus_io.p1_has_data, bus_io.p0_has_data};
  assign wr  = {bus_io.p3_wr_en, bus_io.p2_wr_en, bus_io.p1_wr_en, bus_io.p0_wr_en};
  assign din[0] = bus_io.p0_din;
  assign din[1] = bus_io.p1_din;
  assign din[2] = bus_io.p2_din;
  assign din[3] = bus_io.p3_din;
  assign ctx[0] = bus_io.p0_ctx;
  assign ctx[1] = bus_io.p1_ctx;
  assign ctx[2] = bus_io.p2_ctx;
  assign ctx[3] = bus_io.p3_ctx;

  logic [31:0]  slot_q [NumSlots];
  logic [31:0]  slot_d [NumSlots];
  logic [3:0]   tag_q  [NumSlots];
  logic [3:0]   tag_d  [NumSlots];
  logic [2:0]   count_q, count_d;
  logic         inflight_q, inflight_d;
  logic         valid_q, valid_d;
  logic [255:0] dout_q, dout_d;

  logic         out_free;
  logic         seal;
  logic         req_ok;
  logic [3:0]   req;
  logic         cap;
  logic [1:0]   cap_port;
  logic [2:0]   base;
  logic [255:0] packed_word;

  always_comb begin
    out_free = !valid_q || bus_io.rd_en;
    seal     = out_free &&
               ((count_q == 3'd7) || ((count_q != 3'd0) && !inflight_q && (has == 4'b0000)));
    // A seal frees the whole pack this edge, so a request may go out even when full.
    req_ok   = (({1'b0, count_q} + {3'b000, inflight_q}) < 4'd7) || seal;

    req = 4'b0000;
    if (!rst && req_ok) begin
      if (has[0])      req = 4'b0001;
      else if (has[1]) req = 4'b0010;
      else if (has[2]) req = 4'b0100;
      else if (has[3]) req = 4'b1000;
    end

    cap      = (wr != 4'b0000);
    cap_port = 2'd0;
    if (wr[0])      cap_port = 2'd0;
    else if (wr[1]) cap_port = 2'd1;
    else if (wr[2]) cap_port = 2'd2;
    else if (wr[3]) cap_port = 2'd3;

    base    = seal ? 3'd0 : count_q;
    count_d = base;
    slot_d  = slot_q;
    tag_d   = tag_q;
    if (cap && (base != 3'd7)) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (base == 3'(i)) begin
          slot_d[i] = din[cap_port];
          tag_d[i]  = {ctx[cap_port], cap_port};
        end
      end
      count_d = base + 3'd1;
    end

    inflight_d = (req != 4'b0000);

    // Slots at or beyond count hold stale data from earlier packs; mask them to zero.
    packed_word = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (3'(i) < count_q) begin
        packed_word[32*i +: 32]      = slot_q[i];
        packed_word[224 + 4*i +: 4]  = tag_q[i];
      end
    end
    packed_word[255:252] = {1'b0, count_q};

    valid_d = valid_q;
    dout_d  = dout_q;
    if (seal) begin
      valid_d = 1'b1;
      dout_d  = packed_word;
    end else if (bus_io.rd_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 3'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= slot_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  assign bus_io.dout        = dout_q;
  assign bus_io.valid       = valid_q;
  assign bus_io.p0_req_data = req[0];
  assign bus_io.p1_req_data = req[1];
  assign bus_io.p2_req_data = req[2];
  assign bus_io.p3_req_data = req[3];

endmodule

// File: tb/tb_pcileech_tx_pack4.sv
// Bench for pcileech_tx_pack4: FWNFT source FIFO models, a scoreboard of expected output
// words, and a monitor comparing every accepted output word against it.
module tb_pcileech_tx_pack4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcileech_tx_pack4_if bus ();

  pcileech_tx_pack4 dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  logic [3:0]  has;
  logic [3:0]  wr;
  logic [3:0]  req;
  logic [31:0] din [4];
  logic [1:0]  ctx [4];
  logic        rd;

  assign bus.p0_has_data = has[0];
  assign bus.p1_has_data = has[1];
  assign bus.p2_has_data = has[2];
  assign bus.p3_has_data = has[3];
  assign bus.p0_wr_en = wr[0];
  assign bus.p1_wr_en = wr[1];
  assign bus.p2_wr_en = wr[2];
  assign bus.p3_wr_en = wr[3];
  assign bus.p0_din = din[0];
  assign bus.p1_din = din[1];
  assign bus.p2_din = din[2];
  assign bus.p3_din = din[3];
  assign bus.p0_ctx = ctx[0];
  assign bus.p1_ctx = ctx[1];
  assign bus.p2_ctx = ctx[2];
  assign bus.p3_ctx = ctx[3];
  assign bus.rd_en  = rd;
  assign req = {bus.p3_req_data, bus.p2_req_data, bus.p1_req_data, bus.p0_req_data};

  logic [33:0]  src_q [4][$];
  logic [3:0]   inj_v = 4'b0000;
  logic [33:0]  inj_w [4];
  logic [255:0] sb [$];
  logic [31:0]  acc_d [$];
  logic [3:0]   acc_t [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input logic [31:0] d, input logic [1:0] c);
    src_q[n].push_back({c, d});
    has[n] = 1'b1;
  endtask

  task automatic exp_add(input int n, input logic [31:0] d, input logic [1:0] c);
    acc_d.push_back(d);
    acc_t.push_back({c, 2'(n)});
  endtask

  task automatic exp_seal();
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < acc_d.size(); i++) begin
      w[32*i +: 32]     = acc_d[i];
      w[224 + 4*i +: 4] = acc_t[i];
    end
    w[255:252] = 4'(acc_d.size());
    sb.push_back(w);
    acc_d.delete();
    acc_t.delete();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int i;
    i = 0;
    while (sb.size() != 0 && i < max_cycles) begin
      step(1);
      i++;
    end
    check(name, 256'(sb.size()), 256'd0);
    step(4);
  endtask

  // Source FIFO model: a request seen in cycle t returns data with wr_en in cycle t+1.
  initial begin
    logic [3:0]  snap;
    logic [33:0] w;
    has = 4'b0000;
    wr  = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      din[n] = '0;
      ctx[n] = '0;
    end
    forever begin
      @(negedge clk);
      snap = req;
      @(posedge clk);
      #2;
      wr = 4'b0000;
      for (int n = 0; n < 4; n++) begin
        if (snap[n] && src_q[n].size() != 0) begin
          w = src_q[n].pop_front();
          din[n] = w[31:0];
          ctx[n] = w[33:32];
          wr[n]  = 1'b1;
        end else if (inj_v[n]) begin
          din[n] = inj_w[n][31:0];
          ctx[n] = inj_w[n][33:32];
          wr[n]  = 1'b1;
        end
        has[n] = (src_q[n].size() != 0);
      end
      inj_v = 4'b0000;
    end
  end

  // Monitor: one-request-per-cycle rule and scoreboard compare on every accepted word.
  initial begin
    logic [255:0] e;
    forever begin
      @(negedge clk);
      check("req_onehot0", 256'($onehot0(req)), 256'd1);
      if (bus.valid && rd) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", bus.dout);
        end else begin
          e = sb.pop_front();
          check("dout", bus.dout, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] pat;
    rd = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    has = 4'b1111;
    #1;
    check("rst_req", 256'(req), 256'd0);
    check("rst_valid", 256'(bus.valid), 256'd0);
    check("rst_dout", bus.dout, 256'd0);
    has = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);

    // Single word on port 3: valid in cycle 3.
    push(3, 32'h0000_0003, 2'b00);
    sb.push_back({4'd1, 24'h0, 4'b0011, 192'h0, 32'h0000_0003});
    step(2);
    check("t1_valid_c2", 256'(bus.valid), 256'd0);
    step(1);
    check("t1_valid_c3", 256'(bus.valid), 256'd1);
    drain("t1_drain", 20);

    // Ports 0 and 2, three words each: port 0 first, one word of count 6.
    for (int i = 0; i < 3; i++) push(0, 32'hA000_0000 + 32'(i), 2'b01);
    for (int i = 0; i < 3; i++) push(2, 32'hC000_0000 + 32'(i), 2'b11);
    for (int i = 0; i < 3; i++) exp_add(0, 32'hA000_0000 + 32'(i), 2'b01);
    for (int i = 0; i < 3; i++) exp_add(2, 32'hC000_0000 + 32'(i), 2'b11);
    exp_seal();
    drain("t2_drain", 40);

    // Port 0 streaming 20 words with rd_en high: counts 7, 7, 6 and 7-on/1-off requests.
    for (int i = 0; i < 20; i++) push(0, 32'hB000_0000 + 32'(i), 2'(i));
    for (int i = 0; i < 20; i++) begin
      exp_add(0, 32'hB000_0000 + 32'(i), 2'(i));
      if (i == 6 || i == 13 || i == 19) exp_seal();
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat[i] = req[0];
      @(posedge clk);
      #1;
    end
    check("t3_req_pattern", 256'(pat), 256'h7F7F);
    drain("t3_drain", 60);

    // Back-pressure: 15 words on port 1 with rd_en low.
    rd = 1'b0;
    for (int i = 0; i < 15; i++) push(1, 32'hD000_0000 + 32'(i), 2'b10);
    for (int i = 0; i < 15; i++) begin
      exp_add(1, 32'hD000_0000 + 32'(i), 2'b10);
      if (i == 6 || i == 13 || i == 14) exp_seal();
    end
    step(24);
    check("t4_valid_held", 256'(bus.valid), 256'd1);
    check("t4_stall_req", 256'(req), 256'd0);
    check("t4_has_pending", 256'(has[1]), 256'd1);
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    check("t4_valid_after_read", 256'(bus.valid), 256'd1);
    check("t4_sb_left", 256'(sb.size()), 256'd2);
    step(4);
    rd = 1'b1;
    drain("t4_drain", 30);

    // Reset mid-stream with an unread word and a partial pack (count 4, inflight 1).
    rd = 1'b0;
    push(3, 32'hDEAD_0003, 2'b11);
    step(4);
    check("t5_valid_before", 256'(bus.valid), 256'd1);
    for (int i = 0; i < 10; i++) push(2, 32'hF000_0000 + 32'(i), 2'b00);
    step(5);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 256'(bus.valid), 256'd0);
    check("t5_rst_req", 256'(req), 256'd0);
    check("t5_rst_dout", bus.dout, 256'd0);
    for (int n = 0; n < 4; n++) src_q[n].delete();
    has = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd  = 1'b1;

    // First cycle after reset: simultaneous unsolicited wr_en on ports 1 and 3.
    inj_w[1] = {2'b10, 32'h1111_1111};
    inj_w[3] = {2'b01, 32'h3333_3333};
    inj_v = 4'b1010;
    exp_add(1, 32'h1111_1111, 2'b10);
    exp_seal();
    drain("t6_drain", 20);

    push(2, 32'hE000_0000, 2'b01);
    push(2, 32'hE000_0001, 2'b10);
    exp_add(2, 32'hE000_0000, 2'b01);
    exp_add(2, 32'hE000_0001, 2'b10);
    exp_seal();
    drain("t5_post_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
